// File: rtl/axis_read_address_pkg.sv
// Shared AXI constants and helpers for the
// read-address issue stage.
package axis_read_address_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int AXI_4K_BYTES = 4096;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_read_address.sv
// AXI AR issuer: splits one configured transfer
// into INCR bursts bounded by BURST_NB and 4 KB.
module axis_read_address
  import axis_read_address_pkg::*;
#(
  parameter int CONFIG_AWIDTH  = 32,
  parameter int CONFIG_DWIDTH  = 32,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_LEN_WIDTH  = 8,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int BURST_NB       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CONFIG_AWIDTH-1:0]  cfg_address,
  input  logic [CONFIG_DWIDTH-1:0]  cfg_length,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  output logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
  output logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
  output logic [2:0]                axi_arsize,
  output logic [1:0]                axi_arburst,
  output logic                      axi_arvalid,
  input  logic                      axi_arready,
  output logic                      done
);

  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int SIZE  = clog2(BYTES);
  localparam int PW    = 13;

  localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN =
    ~(AXI_ADDR_WIDTH'(BYTES - 1));

  localparam int I_IDLE  = 0;
  localparam int I_SETUP = 1;
  localparam int I_ISSUE = 2;
  localparam int I_DONE  = 3;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    SETUP = 4'b0010,
    ISSUE = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  state_t state, state_n;

  logic [AXI_ADDR_WIDTH-1:0] addr;
  logic [CONFIG_DWIDTH-1:0]  remain;
  logic [CONFIG_DWIDTH-1:0]  beats;
  logic [CONFIG_DWIDTH-1:0]  beats_c;
  logic [PW-1:0]             room;
  logic                      hs;

  assign axi_arsize  = 3'(SIZE);
  assign axi_arburst = AXI_BURST_INCR;
  assign hs          = axi_arvalid & axi_arready;

  // beats left before the next 4 KB page
  always_comb begin
    room = (PW'(AXI_4K_BYTES)
           - {1'b0, addr[11:0]}) >> SIZE;
  end

  always_comb begin
    beats_c = remain;
    if (beats_c > CONFIG_DWIDTH'(BURST_NB))
      beats_c = CONFIG_DWIDTH'(BURST_NB);
    if (beats_c > CONFIG_DWIDTH'(room))
      beats_c = CONFIG_DWIDTH'(room);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    cfg_ready   = 1'b0;
    axi_arvalid = 1'b0;
    done        = 1'b0;
    unique case (1'b1)
      state[I_IDLE]: begin
        cfg_ready = 1'b1;
        if (cfg_valid)
          state_n = (cfg_length == '0)
                    ? DONE : SETUP;
      end
      state[I_SETUP]: state_n = ISSUE;
      state[I_ISSUE]: begin
        axi_arvalid = 1'b1;
        if (axi_arready)
          state_n = (remain == beats)
                    ? DONE : SETUP;
      end
      state[I_DONE]: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      remain     <= '0;
      beats      <= '0;
      axi_araddr <= '0;
      axi_arlen  <= '0;
    end else begin
      if (cfg_ready && cfg_valid) begin
        addr   <= AXI_ADDR_WIDTH'(cfg_address)
                  & ALIGN;
        remain <= cfg_length;
      end
      if (state[I_SETUP]) begin
        beats      <= beats_c;
        axi_araddr <= addr;
        axi_arlen  <= AXI_LEN_WIDTH'(beats_c - 1'b1);
      end
      if (hs) begin
        addr   <= addr
                  + (AXI_ADDR_WIDTH'(beats) << SIZE);
        remain <= remain - beats;
      end
    end
  end

endmodule

// File: tb/tb_axis_read_address.sv
// Bench for axis_read_address: vector table,
// corner sequences and randomized transfers.
module tb_axis_read_address;

  logic        clk = 0;
  logic        rst;
  logic [31:0] cfg_address;
  logic [31:0] cfg_length;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_arvalid;
  logic        axi_arready;
  logic        done;

  axis_read_address dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_address (cfg_address),
    .cfg_length  (cfg_length),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .axi_araddr  (axi_araddr),
    .axi_arlen   (axi_arlen),
    .axi_arsize  (axi_arsize),
    .axi_arburst (axi_arburst),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  l;
  } burst_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] l;
    int          nb;
    logic [31:0] fa;
    logic [7:0]  fl;
    logic [31:0] la;
    logic [7:0]  ll;
  } vec_t;

  burst_t got[$];
  burst_t exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_hs = 0;
  bit rmode = 0;

  bit          pv, pr;
  logic [31:0] pa;
  logic [7:0]  pl;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, req);
    end
  endtask

  // reference: greedy split, page and size limited
  function automatic void model(
      input logic [31:0] a0, input int unsigned l);
    logic [31:0] a;
    int unsigned rem, room, b;
    exp_q.delete();
    a   = a0 & ~32'h3;
    rem = l;
    while (rem > 0) begin
      room = (4096 - (a % 4096)) / 4;
      b = rem;
      if (b > 16)   b = 16;
      if (b > room) b = room;
      exp_q.push_back('{a, 8'(b - 1)});
      a   = a + b * 4;
      rem = rem - b;
    end
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rmode) begin
      #1;
      axi_arready = 1'($urandom_range(0, 1));
    end
  end

  // AR monitor: stability, 4 KB rule, capture
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      pv = 0;
    end else begin
      if (pv && !pr) begin
        chk("hold_valid", axi_arvalid, 1);
        chk("hold_addr", axi_araddr, pa);
        chk("hold_len", axi_arlen, pl);
      end
      if (axi_arvalid && axi_arready) begin
        got.push_back('{axi_araddr, axi_arlen});
        last_hs = cyc;
        chk("no_4k_cross",
            (int'(axi_araddr[11:0])
             + (int'(axi_arlen) + 1) * 4) <= 4096,
            1);
      end
      pv = axi_arvalid;
      pr = axi_arready;
      pa = axi_araddr;
      pl = axi_arlen;
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cfg_ready) begin
        ok = 1;
        break;
      end
    end
    chk("idle_seen", ok, 1);
  endtask

  task automatic start(input logic [31:0] a,
                       input logic [31:0] l);
    wait_idle();
    @(posedge clk); #1;
    cfg_address = a;
    cfg_length  = l;
    cfg_valid   = 1;
    @(posedge clk); #1;
    cfg_valid   = 0;
  endtask

  task automatic wait_done(input int budget,
                           output bit ok,
                           output int dc);
    ok = 0;
    dc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        dc = cyc;
        break;
      end
    end
    chk("done_seen", ok, 1);
  endtask

  task automatic wait_arvalid();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (axi_arvalid) begin
        ok = 1;
        break;
      end
    end
    chk("arvalid_seen", ok, 1);
  endtask

  task automatic compare_all(input string tag);
    int n;
    chk({tag, "_nburst"}, got.size(),
        exp_q.size());
    n = got.size() < exp_q.size()
        ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_addr"}, got[i].a, exp_q[i].a);
      chk({tag, "_len"},  got[i].l, exp_q[i].l);
    end
  endtask

  task automatic do_xfer(input logic [31:0] a,
                         input logic [31:0] l,
                         input string tag);
    bit ok;
    int dc;
    got.delete();
    model(a, l);
    start(a, l);
    wait_done(3000, ok, dc);
    compare_all(tag);
    if (ok && exp_q.size() > 0)
      chk({tag, "_done_lat"}, dc - last_hs, 1);
    @(negedge clk);
    chk({tag, "_ready_back"},
        {done, cfg_ready}, 2'b01);
  endtask

  vec_t tbl[7];

  initial begin
    bit ok;
    int dc;
    logic [31:0] ra, rl;

    rst = 1;
    cfg_address = 0;
    cfg_length  = 0;
    cfg_valid   = 0;
    axi_arready = 0;
    #3;
    chk("rst_arsize", axi_arsize, 3'd2);
    chk("rst_arburst", axi_arburst, 2'b01);
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_arlen", axi_arlen, 0);
    chk("rst_done", done, 0);
    #24 rst = 0;

    tbl[0] = '{32'h000, 40, 3,
               32'h000, 15, 32'h080, 7};
    tbl[1] = '{32'hFF0, 16, 2,
               32'hFF0, 3, 32'h1000, 11};
    tbl[2] = '{32'h003, 1, 1,
               32'h000, 0, 32'h000, 0};
    tbl[3] = '{32'hFC0, 16, 1,
               32'hFC0, 15, 32'hFC0, 15};
    tbl[4] = '{32'hFFC, 2, 2,
               32'hFFC, 0, 32'h1000, 0};
    tbl[5] = '{32'h2000, 17, 2,
               32'h2000, 15, 32'h2040, 0};
    tbl[6] = '{32'hFFFF_FFF8, 4, 2,
               32'hFFFF_FFF8, 1, 32'h0, 1};

    rmode = 0;
    axi_arready = 1;
    for (int i = 0; i < 7; i++) begin
      do_xfer(tbl[i].a, tbl[i].l, "tbl");
      chk("tbl_n", got.size(), tbl[i].nb);
      if (got.size() > 0) begin
        chk("tbl_fa", got[0].a, tbl[i].fa);
        chk("tbl_fl", got[0].l, tbl[i].fl);
        chk("tbl_la", got[got.size()-1].a,
            tbl[i].la);
        chk("tbl_ll", got[got.size()-1].l,
            tbl[i].ll);
      end
    end

    // zero length
    got.delete();
    wait_idle();
    @(posedge clk); #1;
    cfg_address = 32'h40;
    cfg_length  = 0;
    cfg_valid   = 1;
    @(negedge clk);
    chk("z_T", {done, cfg_ready}, 2'b01);
    @(posedge clk); #1;
    cfg_valid = 0;
    @(negedge clk);
    chk("z_T1", {done, cfg_ready, axi_arvalid},
        3'b100);
    @(negedge clk);
    chk("z_T2", {done, cfg_ready, axi_arvalid},
        3'b010);
    chk("z_nburst", got.size(), 0);

    // backpressure and accept latency
    got.delete();
    model(32'h0, 40);
    axi_arready = 0;
    wait_idle();
    @(posedge clk); #1;
    cfg_address = 0;
    cfg_length  = 40;
    cfg_valid   = 1;
    @(negedge clk);
    chk("bp_T_valid", axi_arvalid, 0);
    @(posedge clk); #1;
    cfg_valid = 0;
    @(negedge clk);
    chk("bp_T1_valid", axi_arvalid, 0);
    @(negedge clk);
    chk("bp_T2_valid", axi_arvalid, 1);
    chk("bp_addr", axi_araddr, 32'h0);
    chk("bp_len", axi_arlen, 8'd15);
    repeat (4) begin
      @(negedge clk); #1;
      chk("bp_stall_valid", axi_arvalid, 1);
      chk("bp_stall_hs", got.size(), 0);
    end
    @(posedge clk); #1;
    axi_arready = 1;
    @(posedge clk); #1;
    axi_arready = 0;
    @(negedge clk); #1;
    chk("bp_one_hs", got.size(), 1);
    chk("bp_bubble", axi_arvalid, 0);
    @(negedge clk);
    chk("bp_next_valid", axi_arvalid, 1);
    chk("bp_next_addr", axi_araddr, 32'h40);
    rmode = 1;
    wait_done(500, ok, dc);
    compare_all("bp");

    // async reset while in ISSUE
    rmode = 0;
    @(posedge clk); #1;
    axi_arready = 0;
    start(32'h800, 40);
    wait_arvalid();
    #2 rst = 1;
    #1;
    chk("ar_rst_valid", axi_arvalid, 0);
    chk("ar_rst_ready", cfg_ready, 1);
    chk("ar_rst_done", done, 0);
    #1 rst = 0;
    axi_arready = 1;
    do_xfer(32'h100, 4, "post_rst");
    chk("post_rst_n", got.size(), 1);

    // config offered while busy
    rmode = 1;
    got.delete();
    model(32'h0, 40);
    start(32'h0, 40);
    wait_arvalid();
    @(posedge clk); #1;
    cfg_address = 32'h700;
    cfg_length  = 5;
    cfg_valid   = 1;
    @(posedge clk); #1;
    cfg_valid   = 0;
    @(posedge clk); #1;
    cfg_address = 32'h500;
    cfg_length  = 8;
    cfg_valid   = 1;
    wait_done(500, ok, dc);
    compare_all("busy_a");
    chk("busy_no_early", cfg_ready, 0);
    got.delete();
    model(32'h500, 8);
    wait_idle();
    @(posedge clk); #1;
    cfg_valid = 0;
    wait_done(500, ok, dc);
    compare_all("busy_b");

    // randomized transfers
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1)
        ra = {ra[31:12], 4'hF, ra[7:0]};
      rl = $urandom_range(0, 60);
      do_xfer(ra, rl, "rnd");
    end

    rmode = 0;
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
